// File: rtl/crp16_mem_arbiter.sv
// Single-port RAM arbiter for the crp16 core: data, fetch and debug/loader requesters.
// Optional debug bus lock is enabled by defining CRP16_ARB_LOCK_EN.
//
// state     | meaning
// ST_IDLE   | normal arbitration: data > fetch > debug, starvation override for debug
// ST_LOCKED | debug owns the RAM; only x_req can be granted
module crp16_mem_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    input  logic        x_req,
    input  logic        x_we,
    input  logic [15:0] x_addr,
    input  logic [15:0] x_wdata,
`ifdef CRP16_ARB_LOCK_EN
    input  logic        x_lock,
`endif
    output logic        x_gnt,
    output logic        x_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    input  logic [15:0] mem_q,
    output logic        busy
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_D    = 2'd1;
    localparam logic [1:0] TAG_I    = 2'd2;
    localparam logic [1:0] TAG_X    = 2'd3;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [7:0]  starve_q, starve_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  tag_q [READ_LAT];
    logic [1:0]  tag_d [READ_LAT];
    logic [1:0]  push_tag;
    logic        gnt_d, gnt_i, gnt_x, wren;
    logic        lock_in;

`ifdef CRP16_ARB_LOCK_EN
    assign lock_in = x_lock;
`else
    assign lock_in = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        data_d   = data_q;
        gnt_d    = 1'b0;
        gnt_i    = 1'b0;
        gnt_x    = 1'b0;
        wren     = 1'b0;
        push_tag = TAG_NONE;

        // Grants are suppressed while reset is held so nothing reaches the RAM.
        if (resetn) begin
            if (state_q == ST_LOCKED) begin
                gnt_x = x_req;
            end else if (x_req && (starve_q == LIMIT)) begin
                gnt_x = 1'b1;
            end else if (d_req) begin
                gnt_d = 1'b1;
            end else if (i_req) begin
                gnt_i = 1'b1;
            end else if (x_req) begin
                gnt_x = 1'b1;
            end
        end

        if (gnt_d) begin
            addr_d   = d_addr;
            data_d   = d_wdata;
            wren     = d_we;
            push_tag = d_we ? TAG_NONE : TAG_D;
        end else if (gnt_i) begin
            addr_d   = i_addr;
            push_tag = TAG_I;
        end else if (gnt_x) begin
            addr_d   = x_addr;
            data_d   = x_wdata;
            wren     = x_we;
            push_tag = x_we ? TAG_NONE : TAG_X;
        end

        if (state_q != ST_LOCKED) begin
            if (!x_req || gnt_x) begin
                starve_d = 8'd0;
            end else if (starve_q != LIMIT) begin
                starve_d = starve_q + 8'd1;
            end
        end

        if (gnt_x) begin
            state_d = lock_in ? ST_LOCKED : ST_IDLE;
        end

        tag_d[0] = push_tag;
        for (int k = 1; k < READ_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            starve_q <= 8'd0;
            addr_q   <= 16'd0;
            data_q   <= 16'd0;
            for (int k = 0; k < READ_LAT; k++) begin
                tag_q[k] <= TAG_NONE;
            end
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            for (int k = 0; k < READ_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < READ_LAT; k++) begin
            busy = busy | (tag_q[k] != TAG_NONE);
        end
    end

    assign d_gnt    = gnt_d;
    assign i_gnt    = gnt_i;
    assign x_gnt    = gnt_x;
    assign mem_addr = addr_d;
    assign mem_data = data_d;
    assign mem_wren = wren;
    assign rdata    = mem_q;
    // The oldest tag lines up with mem_q for the read it belongs to.
    assign d_rvalid = resetn && (tag_q[READ_LAT-1] == TAG_D);
    assign i_rvalid = resetn && (tag_q[READ_LAT-1] == TAG_I);
    assign x_rvalid = resetn && (tag_q[READ_LAT-1] == TAG_X);

endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// Scoreboard bench for crp16_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and RAM contents.
module tb_crp16_mem_arbiter;

    localparam int RL = 2;
    localparam int SL = 8;

    logic        clock = 1'b0;
    logic        resetn;
    logic        d_req, d_we, i_req, x_req, x_we;
    logic [15:0] d_addr, d_wdata, i_addr, x_addr, x_wdata;
    logic        d_gnt, d_rvalid, i_gnt, i_rvalid, x_gnt, x_rvalid;
    logic [15:0] rdata, mem_addr, mem_data, mem_q;
    logic        mem_wren, busy;
`ifdef CRP16_ARB_LOCK_EN
    logic        x_lock;
`endif

    always #5 clock = ~clock;

    crp16_mem_arbiter #(.READ_LAT(RL), .STARVE_LIMIT(SL)) dut (
        .clock(clock), .resetn(resetn),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
`ifdef CRP16_ARB_LOCK_EN
        .x_lock(x_lock),
`endif
        .x_gnt(x_gnt), .x_rvalid(x_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q), .busy(busy)
    );

    // Write-first synchronous RAM with RL cycles of read latency.
    logic [15:0] ram [65536];
    logic [15:0] ram_pipe [RL];
    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr] <= mem_data;
        ram_pipe[0] <= mem_wren ? mem_data : ram[mem_addr];
        for (int k = 1; k < RL; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign mem_q = ram_pipe[RL-1];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          rd_cyc[$];
    logic [15:0] ref_mem [65536];
    int          m_cnt = 0;
    bit          m_lock = 1'b0;
    logic [15:0] m_addr = 16'd0;
    logic [15:0] m_data = 16'd0;

    function automatic logic cur_lock();
`ifdef CRP16_ARB_LOCK_EN
        return x_lock;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick();
        if (m_lock) return x_req ? 3 : 0;
        if (x_req && m_cnt == SL) return 3;
        if (d_req) return 1;
        if (i_req) return 2;
        if (x_req) return 3;
        return 0;
    endfunction

    always @(negedge clock) begin
        int w;
        logic [2:0] gv;
        logic [15:0] ea, ed;
        logic ewe;
        if (!resetn) begin
            chk("gnt_in_reset", {29'd0, d_gnt, i_gnt, x_gnt}, 32'd0);
            m_cnt = 0; m_lock = 1'b0; m_addr = 16'd0; m_data = 16'd0;
            sb.delete();
            rd_cyc.delete();
        end else begin
            w  = pick();
            gv = (w == 1) ? 3'b100 : (w == 2) ? 3'b010 : (w == 3) ? 3'b001 : 3'b000;
            chk("grant", {29'd0, d_gnt, i_gnt, x_gnt}, {29'd0, gv});
            ea = m_addr; ed = m_data; ewe = 1'b0;
            if (w == 1) begin ea = d_addr; ed = d_wdata; ewe = d_we; end
            if (w == 2) begin ea = i_addr; end
            if (w == 3) begin ea = x_addr; ed = x_wdata; ewe = x_we; end
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, ea});
            chk("mem_wren", {31'd0, mem_wren}, {31'd0, ewe});
            if (w != 2) chk("mem_data", {16'd0, mem_data}, {16'd0, ed});
            while (rd_cyc.size() > 0 && rd_cyc[0] < cyc - RL) void'(rd_cyc.pop_front());
            chk("busy", {31'd0, busy}, {31'd0, rd_cyc.size() > 0});
            if (w != 0) begin
                if (ewe) ref_mem[ea] = ed;
                else begin
                    sb.push_back('{owner: w, data: ref_mem[ea], due: cyc + RL});
                    rd_cyc.push_back(cyc);
                end
                m_addr = ea;
                if (w != 2) m_data = ed;
            end
            if (w == 3) m_cnt = 0;
            else if (m_lock) m_cnt = m_cnt;
            else if (x_req) m_cnt = (m_cnt < SL) ? m_cnt + 1 : SL;
            else m_cnt = 0;
            if (w == 3) m_lock = cur_lock();
        end
    end

    // ---------------- read-data monitor ----------------
    always @(negedge clock) begin
        exp_t e;
        logic [2:0] ov;
        if (resetn) begin
            if (d_rvalid || i_rvalid || x_rvalid) begin
                if (sb.size() == 0 || sb[0].due != cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_rvalid: got %b expected none (cycle %0d)",
                             {d_rvalid, i_rvalid, x_rvalid}, cyc);
                end else begin
                    e  = sb.pop_front();
                    ov = (e.owner == 1) ? 3'b100 : (e.owner == 2) ? 3'b010 : 3'b001;
                    chk("rvalid_owner", {29'd0, d_rvalid, i_rvalid, x_rvalid}, {29'd0, ov});
                    chk("rdata", {16'd0, rdata}, {16'd0, e.data});
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL missing_rvalid: got none expected owner %0d data %0h (cycle %0d)",
                         e.owner, e.data, cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        d_req = 0; i_req = 0; x_req = 0; d_we = 0; x_we = 0;
`ifdef CRP16_ARB_LOCK_EN
        x_lock = 0;
`endif
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_flags"}, {24'd0, d_gnt, i_gnt, x_gnt, d_rvalid, i_rvalid, x_rvalid, mem_wren, busy}, 32'd0);
        chk({name, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({name, "_mem_data"}, {16'd0, mem_data}, 32'd0);
    endtask

    task automatic wait_rvalid(input int which, input int limit, output int waited);
        waited = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clock);
            if ((which == 1 && d_rvalid) || (which == 2 && i_rvalid) || (which == 3 && x_rvalid)) begin
                waited = n;
                break;
            end
        end
    endtask

    initial begin
        int n, waited, seen;
        logic ig, dg, ig2, xg;
        resetn = 0;
        d_addr = 0; d_wdata = 0; i_addr = 0; x_addr = 0; x_wdata = 0;
        idle_all();
        for (int k = 0; k < 65536; k++) begin
            ram[k] = 16'($urandom);
            ref_mem[k] = ram[k];
        end
        ram[16'h0005] = 16'hBEEF; ref_mem[16'h0005] = 16'hBEEF;
        ram[16'h0006] = 16'hCAFE; ref_mem[16'h0006] = 16'hCAFE;

        tick(); tick();
        @(negedge clock);
        chk_all_zero("reset");
        tick();
        resetn = 1;

        // Priority: all three request in one cycle.
        d_req = 1; d_we = 0; d_addr = 16'h0100;
        i_req = 1; i_addr = 16'h0200;
        x_req = 1; x_we = 0; x_addr = 16'h0300;
        @(negedge clock);
        chk("prio_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("prio_d_addr", {16'd0, mem_addr}, 32'h0100);
        tick(); d_req = 0;
        @(negedge clock);
        chk("prio_i_gnt", {31'd0, i_gnt}, 32'd1);
        chk("prio_i_addr", {16'd0, mem_addr}, 32'h0200);
        tick(); i_req = 0;
        @(negedge clock);
        chk("prio_x_gnt", {31'd0, x_gnt}, 32'd1);
        tick(); x_req = 0;
        repeat (3) tick();

        // Latency and back-to-back reads.
        i_req = 1; i_addr = 16'h0005;
        @(negedge clock);
        chk("lat_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick(); i_addr = 16'h0006;
        tick(); i_req = 0;
        wait_rvalid(2, 4, waited);
        chk("lat_first_delay", waited, 1);
        chk("lat_first_data", {16'd0, rdata}, 32'hBEEF);
        @(negedge clock);
        chk("lat_second_valid", {31'd0, i_rvalid}, 32'd1);
        chk("lat_second_data", {16'd0, rdata}, 32'hCAFE);
        repeat (2) tick();

        // Debug write then data read of the same address.
        x_req = 1; x_we = 1; x_addr = 16'h0040; x_wdata = 16'h1234;
        @(negedge clock);
        chk("wr_x_gnt", {31'd0, x_gnt}, 32'd1);
        chk("wr_wren", {31'd0, mem_wren}, 32'd1);
        tick(); x_req = 0; x_we = 0;
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        @(negedge clock);
        chk("raw_d_gnt", {31'd0, d_gnt}, 32'd1);
        tick(); d_req = 0;
        wait_rvalid(1, 5, waited);
        chk("raw_data", {16'd0, rdata}, 32'h1234);
        repeat (3) tick();

        // Starvation: fetch streams while debug waits; repeated to show the counter restarts.
        i_req = 1; i_addr = 16'h0080;
        x_req = 1; x_we = 0; x_addr = 16'h0077;
        for (int r = 0; r < 2; r++) begin
            n = 0; ig = 1'b1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clock);
                if (x_gnt) begin n = c; ig = i_gnt; break; end
                tick();
                i_addr = i_addr + 16'd1;
            end
            chk("starve_cycle", n, 9);
            chk("starve_i_gnt", {31'd0, ig}, 32'd0);
            tick();
            x_addr = x_addr + 16'd1;
        end
        idle_all();
        repeat (4) tick();

`ifdef CRP16_ARB_LOCK_EN
        x_req = 1; x_lock = 1; x_we = 0; x_addr = 16'h0050;
        @(negedge clock);
        chk("lock_x_gnt", {31'd0, x_gnt}, 32'd1);
        tick(); x_req = 0; x_lock = 0;
        d_req = 1; d_we = 0; d_addr = 16'h0060;
        dg = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            dg = dg | d_gnt;
            tick();
        end
        chk("lock_d_blocked", {31'd0, dg}, 32'd0);
        x_req = 1; x_lock = 0; x_addr = 16'h0051;
        @(negedge clock);
        chk("unlock_x_gnt", {31'd0, x_gnt}, 32'd1);
        chk("unlock_d_gnt", {31'd0, d_gnt}, 32'd0);
        tick(); x_req = 0;
        @(negedge clock);
        chk("after_unlock_d_gnt", {31'd0, d_gnt}, 32'd1);
        tick(); d_req = 0;
        repeat (4) tick();
`endif

        // Reset while a fetch read is in flight.
        i_req = 1; i_addr = 16'h0010;
        @(negedge clock);
        chk("rst_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick(); i_req = 0; resetn = 0;
        tick();
        @(negedge clock);
        chk_all_zero("rst_mid");
        tick(); resetn = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (i_rvalid) seen++;
            tick();
        end
        chk("rst_no_rvalid", seen, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            dg = d_gnt; ig2 = i_gnt; xg = x_gnt;
            tick();
            if (d_req && dg) d_req = 0;
            if (i_req && ig2) i_req = 0;
            if (x_req && xg) x_req = 0;
            if (!d_req && $urandom_range(0, 99) < 55) begin
                d_req = 1; d_we = $urandom_range(0, 2) == 0;
                d_addr = 16'($urandom_range(0, 63)); d_wdata = 16'($urandom);
            end
            if (!i_req && $urandom_range(0, 99) < 55) begin
                i_req = 1; i_addr = 16'($urandom_range(0, 63));
            end
            if (!x_req && $urandom_range(0, 99) < 35) begin
                x_req = 1; x_we = $urandom_range(0, 2) == 0;
                x_addr = 16'($urandom_range(0, 63)); x_wdata = 16'($urandom);
`ifdef CRP16_ARB_LOCK_EN
                x_lock = $urandom_range(0, 4) == 0;
`endif
            end
        end
        idle_all();
        repeat (RL + 4) tick();
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d reads outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
